// File: rtl/uart_cmd_decoder.sv
`default_nettype none
// ============================================================================
// Module   : uart_cmd_decoder
// Purpose  : Decodes host command bytes arriving from the UART receiver.
//            Single-byte CMD_START requests a BIP start; CMD_LOAD opens a
//            frame carrying a 16-bit operand (low byte first). Frames that
//            stall longer than TIMEOUT_TICKS baud ticks between bytes are
//            aborted with an error.
// Optional : `define UART_CMD_CHECKSUM_EN adds a trailing checksum byte
//            (CMD_LOAD ^ lo ^ hi) to every load frame.
// Ports    : clk, reset      - clock, synchronous active-high reset
//            tick            - baud tick shared with the receiver
//            rx_data         - received byte, valid with rx_done_tick
//            rx_done_tick    - one-cycle new-byte strobe
//            bip_busy        - BIP core is executing
//            start_bip       - one-cycle start pulse
//            ld_data         - last committed load operand
//            ld_valid        - one-cycle strobe, ld_data just updated
//            err, err_code   - one-cycle error strobe and its cause
//                              (00 busy, 01 opcode, 10 timeout, 11 checksum)
// Revision : 1.0 - initial release
// ============================================================================
module uart_cmd_decoder #(
  parameter int                DBIT          = 8,
  parameter logic [DBIT-1:0]   CMD_START     = 8'h73,
  parameter logic [DBIT-1:0]   CMD_LOAD      = 8'h6C,
  parameter logic [15:0]       TIMEOUT_TICKS = 16'd4800
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            tick,
  input  logic [DBIT-1:0] rx_data,
  input  logic            rx_done_tick,
  input  logic            bip_busy,
  output logic            start_bip,
  output logic [15:0]     ld_data,
  output logic            ld_valid,
  output logic            err,
  output logic [1:0]      err_code
);

  localparam logic [1:0] ERR_BUSY    = 2'b00;
  localparam logic [1:0] ERR_OPCODE  = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT = 2'b10;
`ifdef UART_CMD_CHECKSUM_EN
  localparam logic [1:0] ERR_CHKSUM  = 2'b11;
`endif

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LD_LO  = 2'd1,
    LD_HI  = 2'd2,
    LD_CHK = 2'd3
  } state_t;

  state_t      state, state_n;
  logic [15:0] cnt, cnt_n;
  logic [15:0] cnt_inc;
  logic [7:0]  lo, lo_n;
  logic [7:0]  hi, hi_n;
  logic [7:0]  byte_in;
  logic        start_n, ld_valid_n, err_n;
  logic [1:0]  err_code_n;
  logic [15:0] ld_data_n;

  // Operand bytes are 8 bits regardless of DBIT.
  assign byte_in = rx_data[7:0];
  // Saturating increment: the counter must never wrap back to zero.
  assign cnt_inc = (cnt == 16'hFFFF) ? cnt : cnt + 16'd1;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= 16'd0;
      lo        <= 8'd0;
      hi        <= 8'd0;
      start_bip <= 1'b0;
      ld_valid  <= 1'b0;
      err       <= 1'b0;
      err_code  <= 2'b00;
      ld_data   <= 16'h0000;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      lo        <= lo_n;
      hi        <= hi_n;
      start_bip <= start_n;
      ld_valid  <= ld_valid_n;
      err       <= err_n;
      err_code  <= err_code_n;
      ld_data   <= ld_data_n;
    end
  end

  always_comb begin
    state_n    = state;
    cnt_n      = cnt;
    lo_n       = lo;
    hi_n       = hi;
    start_n    = 1'b0;
    ld_valid_n = 1'b0;
    err_n      = 1'b0;
    err_code_n = err_code;
    ld_data_n  = ld_data;

    if (state == IDLE) begin
      cnt_n = 16'd0;
      if (rx_done_tick) begin
        if (rx_data == CMD_START) begin
          if (bip_busy) begin
            err_n      = 1'b1;
            err_code_n = ERR_BUSY;
          end else begin
            start_n = 1'b1;
          end
        end else if (rx_data == CMD_LOAD) begin
          state_n = LD_LO;
        end else begin
          err_n      = 1'b1;
          err_code_n = ERR_OPCODE;
        end
      end
    end else if (rx_done_tick) begin
      // A byte always wins over a coincident expiring tick.
      cnt_n = 16'd0;
      case (state)
        LD_LO: begin
          lo_n    = byte_in;
          state_n = LD_HI;
        end
        LD_HI: begin
          hi_n = byte_in;
`ifdef UART_CMD_CHECKSUM_EN
          state_n = LD_CHK;
`else
          ld_data_n  = {byte_in, lo};
          ld_valid_n = 1'b1;
          state_n    = IDLE;
`endif
        end
`ifdef UART_CMD_CHECKSUM_EN
        LD_CHK: begin
          if (byte_in == (CMD_LOAD[7:0] ^ lo ^ hi)) begin
            ld_data_n  = {hi, lo};
            ld_valid_n = 1'b1;
          end else begin
            err_n      = 1'b1;
            err_code_n = ERR_CHKSUM;
          end
          state_n = IDLE;
        end
`endif
        default: state_n = IDLE;
      endcase
    end else if (tick) begin
      if (cnt_inc >= TIMEOUT_TICKS) begin
        err_n      = 1'b1;
        err_code_n = ERR_TIMEOUT;
        cnt_n      = 16'd0;
        state_n    = IDLE;
      end else begin
        cnt_n = cnt_inc;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_cmd_decoder.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_cmd_decoder
// Purpose  : Scoreboard bench for uart_cmd_decoder. Stimulus pushes the
//            expected response (kind, code/data, cycle); a monitor pops and
//            compares whenever the DUT raises start_bip, ld_valid or err.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_cmd_decoder;

  localparam logic [15:0] TO = 16'd8;
  localparam int K_START = 0;
  localparam int K_LD    = 1;
  localparam int K_ERR   = 2;

  typedef struct {
    int          kind;
    logic [1:0]  code;
    logic [15:0] data;
    int          cyc;
  } ev_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        tick = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_done_tick = 1'b0;
  logic        bip_busy = 1'b0;
  logic        start_bip;
  logic [15:0] ld_data;
  logic        ld_valid;
  logic        err;
  logic [1:0]  err_code;

  int  checks = 0;
  int  failures = 0;
  int  cyc = 0;
  ev_t sb[$];

  uart_cmd_decoder #(
    .DBIT(8), .CMD_START(8'h73), .CMD_LOAD(8'h6C), .TIMEOUT_TICKS(TO)
  ) dut (
    .clk(clk), .reset(reset), .tick(tick), .rx_data(rx_data),
    .rx_done_tick(rx_done_tick), .bip_busy(bip_busy),
    .start_bip(start_bip), .ld_data(ld_data), .ld_valid(ld_valid),
    .err(err), .err_code(err_code)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic ev_t mk(input int kind, input logic [1:0] code, input logic [15:0] data);
    ev_t e;
    e.kind = kind; e.code = code; e.data = data; e.cyc = 0;
    return e;
  endfunction

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every output event must match the head of the scoreboard.
  always @(negedge clk) begin
    if (!reset && (start_bip || ld_valid || err)) begin
      checks++;
      if (sb.size() == 0) begin
        failures++;
        $display("FAIL unexpected_event: start=%b ld_valid=%b err=%b code=%b at cyc %0d",
                 start_bip, ld_valid, err, err_code, cyc);
      end else begin
        ev_t e;
        int  k;
        bit  ok;
        e = sb.pop_front();
        k = start_bip ? K_START : (ld_valid ? K_LD : K_ERR);
        ok = ({1'b0, start_bip} + {1'b0, ld_valid} + {1'b0, err}) == 2'd1;
        ok = ok && (k == e.kind) && (cyc == e.cyc);
        if (e.kind == K_LD)  ok = ok && (ld_data === e.data);
        if (e.kind == K_ERR) ok = ok && (err_code === e.code);
        if (!ok) begin
          failures++;
          $display("FAIL event: got kind=%0d code=%b data=%h cyc=%0d (s%b l%b e%b) expected kind=%0d code=%b data=%h cyc=%0d",
                   k, err_code, ld_data, cyc, start_bip, ld_valid, err,
                   e.kind, e.code, e.data, e.cyc);
        end
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input logic busy, input logic tk,
                           input bit exp, input ev_t ev);
    @(posedge clk); #1;
    rx_data = b; rx_done_tick = 1'b1; bip_busy = busy; tick = tk;
    if (exp) begin
      ev.cyc = cyc + 1;
      sb.push_back(ev);
    end
    @(posedge clk); #1;
    rx_data = 8'h00; rx_done_tick = 1'b0; bip_busy = 1'b0; tick = 1'b0;
  endtask

  task automatic plain(input logic [7:0] b);
    send_byte(b, 1'b0, 1'b0, 1'b0, mk(0, 2'b00, 16'h0));
  endtask

  task automatic ticks(input int n, input bit exp_to);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      tick = 1'b1;
      if (exp_to && i == n - 1) begin
        ev_t e;
        e = mk(K_ERR, 2'b10, 16'h0);
        e.cyc = cyc + 1;
        sb.push_back(e);
      end
      @(posedge clk); #1;
      tick = 1'b0;
    end
  endtask

  // Sends lo/hi of a load frame (opcode already sent); the last byte of the
  // frame carries the expected commit and may coincide with a tick.
  task automatic load_tail(input logic [7:0] lo, input logic [7:0] hi, input logic tk_last);
`ifdef UART_CMD_CHECKSUM_EN
    plain(lo);
    plain(hi);
    send_byte(8'h6C ^ lo ^ hi, 1'b0, tk_last, 1'b1, mk(K_LD, 2'b00, {hi, lo}));
`else
    plain(lo);
    send_byte(hi, 1'b0, tk_last, 1'b1, mk(K_LD, 2'b00, {hi, lo}));
`endif
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check("rst_start_bip", {15'd0, start_bip}, 16'd0);
    check("rst_ld_valid",  {15'd0, ld_valid},  16'd0);
    check("rst_err",       {15'd0, err},       16'd0);
    check("rst_err_code",  {14'd0, err_code},  16'd0);
    check("rst_ld_data",   ld_data,            16'h0000);

    // Start accepted / rejected, unknown opcode.
    send_byte(8'h73, 1'b0, 1'b0, 1'b1, mk(K_START, 2'b00, 16'h0));
    send_byte(8'h73, 1'b1, 1'b0, 1'b1, mk(K_ERR, 2'b00, 16'h0));
    send_byte(8'h00, 1'b0, 1'b0, 1'b1, mk(K_ERR, 2'b01, 16'h0));

    // Loads.
    plain(8'h6C); load_tail(8'h34, 8'h12, 1'b0);
    repeat (5) @(posedge clk);
    #1;
    check("ld_hold_1234", ld_data, 16'h1234);
    plain(8'h6C); load_tail(8'hFF, 8'hFF, 1'b0);

    // Timeout: one tick short must not fire, the next one must.
    plain(8'h6C); plain(8'h34);
    ticks(int'(TO) - 1, 1'b0);
    ticks(1, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    check("ld_hold_after_timeout", ld_data, 16'hFFFF);
    send_byte(8'h73, 1'b0, 1'b0, 1'b1, mk(K_START, 2'b00, 16'h0));

    // Opcode values inside a frame are raw data.
    plain(8'h6C); load_tail(8'h73, 8'h6C, 1'b0);

`ifdef UART_CMD_CHECKSUM_EN
    plain(8'h6C); plain(8'h34); plain(8'h12);
    send_byte(8'h4A, 1'b0, 1'b0, 1'b1, mk(K_LD, 2'b00, 16'h1234));
    plain(8'h6C); plain(8'h34); plain(8'h12);
    send_byte(8'h00, 1'b0, 1'b0, 1'b1, mk(K_ERR, 2'b11, 16'h0));
    repeat (2) @(posedge clk);
    #1;
    check("ld_hold_after_chk_err", ld_data, 16'h1234);
`endif

    // Byte coincident with the expiring tick is accepted.
`ifdef UART_CMD_CHECKSUM_EN
    plain(8'h6C); plain(8'h78);
    ticks(int'(TO) - 1, 1'b0);
    send_byte(8'h56, 1'b0, 1'b1, 1'b0, mk(0, 2'b00, 16'h0));
    ticks(int'(TO) - 1, 1'b0);
    send_byte(8'h42, 1'b0, 1'b1, 1'b1, mk(K_LD, 2'b00, 16'h5678));
`else
    plain(8'h6C); plain(8'h78);
    ticks(int'(TO) - 1, 1'b0);
    send_byte(8'h56, 1'b0, 1'b1, 1'b1, mk(K_LD, 2'b00, 16'h5678));
`endif
    ticks(int'(TO) + 2, 1'b0);

    // Reset mid-frame: silent abort, back in IDLE.
    plain(8'h6C); plain(8'h34);
    @(posedge clk); #1;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check("ld_data_after_reset", ld_data, 16'h0000);
    ticks(int'(TO) + 2, 1'b0);
    send_byte(8'h73, 1'b0, 1'b0, 1'b1, mk(K_START, 2'b00, 16'h0));

    repeat (5) @(posedge clk);
    #1;
    check("scoreboard_drained", 16'(sb.size()), 16'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
